// File: rtl/ts_stream_rx.sv
//==============================================================================
// Module   : ts_stream_rx
// Purpose  : MPEG-2 transport-stream receiver. Hunts for the 0x47 sync byte on
//            a FIFO-fed byte stream, verifies packet alignment over LOCK_CNT
//            consecutive packets, then forwards bytes with SOP/EOP framing
//            and extracts the PID / TEI of every packet while locked.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters
//   PKT_LEN    : TS packet length in bytes (default 188)
//   LOCK_CNT   : consecutive good sync bytes needed to lock (default 3)
//   UNLOCK_CNT : consecutive bad sync bytes needed to drop lock (default 2)
// Ports
//   clk        in   1  clock, rising edge
//   rst        in   1  asynchronous active-high reset
//   data_in    in  10  [9] valid, [8] sync flag, [7:0] TS byte
//   locked     out  1  high while in LOCKED state
//   out_valid  out  1  qualifies out_data / out_sop / out_eop
//   out_data   out  8  forwarded TS byte (latency 1)
//   out_sop    out  1  packet byte 0
//   out_eop    out  1  packet byte PKT_LEN-1
//   pid        out 13  PID of the current packet
//   pid_valid  out  1  one-cycle strobe once pid is complete
//   tei        out  1  transport_error_indicator of the current packet
//   err_cnt    out 16  saturating sync-loss counter (only with TS_ERR_CNT_EN)
//   sync_err   out  1  one-cycle pulse on a bad sync byte while locked
// Build option
//   TS_ERR_CNT_EN : when defined, adds the err_cnt port and its counter.
//==============================================================================
`default_nettype none

module ts_stream_rx #(
   parameter int PKT_LEN    = 188,
   parameter int LOCK_CNT   = 3,
   parameter int UNLOCK_CNT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  data_in,
   output logic        locked,
   output logic        out_valid,
   output logic [7:0]  out_data,
   output logic        out_sop,
   output logic        out_eop,
   output logic [12:0] pid,
   output logic        pid_valid,
   output logic        tei,
`ifdef TS_ERR_CNT_EN
   output logic [15:0] err_cnt,
`endif
   output logic        sync_err
);

   localparam int CNT_W  = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam int GOOD_W = $clog2(LOCK_CNT + 1);
   localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);

   localparam logic [CNT_W-1:0]  LAST_POS = CNT_W'(PKT_LEN - 1);
   localparam logic [CNT_W-1:0]  POS_B1   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  POS_B2   = CNT_W'(2);
   localparam logic [GOOD_W-1:0] LOCK_TGT = GOOD_W'(LOCK_CNT);
   localparam logic [BAD_W-1:0]  UNLK_TGT = BAD_W'(UNLOCK_CNT);

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
   logic [GOOD_W-1:0]  good_cnt_q, good_cnt_d;
   logic [BAD_W-1:0]   bad_cnt_q, bad_cnt_d;
   logic               out_valid_q, out_valid_d;
   logic [7:0]         out_data_q, out_data_d;
   logic               out_sop_q, out_sop_d;
   logic               out_eop_q, out_eop_d;
   logic [12:0]        pid_q, pid_d;
   logic               pid_valid_q, pid_valid_d;
   logic               tei_q, tei_d;
   logic               sync_err_q, sync_err_d;

   logic               w_valid;
   logic               w_good;
   logic               w_at_sync;
   logic [CNT_W-1:0]   w_byte_next;
   logic [GOOD_W-1:0]  w_good_inc;
   logic [BAD_W-1:0]   w_bad_inc;

   assign w_valid     = data_in[9];
   assign w_good      = data_in[9] & data_in[8] & (data_in[7:0] == 8'h47);
   assign w_at_sync   = (byte_cnt_q == '0);
   assign w_byte_next = (byte_cnt_q == LAST_POS) ? '0 : byte_cnt_q + CNT_W'(1);
   assign w_good_inc  = good_cnt_q + GOOD_W'(1);
   assign w_bad_inc   = bad_cnt_q + BAD_W'(1);

   //---------------------------------------------------------------------------
   // State / output registers
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_HUNT;
         byte_cnt_q  <= '0;
         good_cnt_q  <= '0;
         bad_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
         pid_q       <= '0;
         pid_valid_q <= 1'b0;
         tei_q       <= 1'b0;
         sync_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         byte_cnt_q  <= byte_cnt_d;
         good_cnt_q  <= good_cnt_d;
         bad_cnt_q   <= bad_cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sop_q   <= out_sop_d;
         out_eop_q   <= out_eop_d;
         pid_q       <= pid_d;
         pid_valid_q <= pid_valid_d;
         tei_q       <= tei_d;
         sync_err_q  <= sync_err_d;
      end
   end

   //---------------------------------------------------------------------------
   // Next-state and output decode
   //---------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      good_cnt_d  = good_cnt_q;
      bad_cnt_d   = bad_cnt_q;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      out_sop_d   = 1'b0;
      out_eop_d   = 1'b0;
      pid_d       = pid_q;
      pid_valid_d = 1'b0;
      tei_d       = tei_q;
      sync_err_d  = 1'b0;

      // Cycles without a valid byte leave every counter and state untouched.
      if (w_valid) begin
         case (state_q)
            ST_HUNT: begin
               if (w_good) begin
                  byte_cnt_d = CNT_W'(1);
                  good_cnt_d = GOOD_W'(1);
                  bad_cnt_d  = '0;
                  if (LOCK_CNT <= 1) begin
                     state_d     = ST_LOCKED;
                     out_valid_d = 1'b1;
                     out_data_d  = data_in[7:0];
                     out_sop_d   = 1'b1;
                  end else begin
                     state_d = ST_VERIFY;
                  end
               end
            end

            ST_VERIFY: begin
               byte_cnt_d = w_byte_next;
               if (w_at_sync) begin
                  if (w_good) begin
                     good_cnt_d = w_good_inc;
                     if (w_good_inc == LOCK_TGT) begin
                        // The sync that completes lock opens the first
                        // forwarded packet.
                        state_d     = ST_LOCKED;
                        bad_cnt_d   = '0;
                        out_valid_d = 1'b1;
                        out_data_d  = data_in[7:0];
                        out_sop_d   = 1'b1;
                     end
                  end else begin
                     // Alignment failed; this byte is consumed, not retried
                     // as a new sync candidate.
                     state_d    = ST_HUNT;
                     byte_cnt_d = '0;
                     good_cnt_d = '0;
                  end
               end
            end

            ST_LOCKED: begin
               byte_cnt_d  = w_byte_next;
               out_valid_d = 1'b1;
               out_data_d  = data_in[7:0];
               out_sop_d   = w_at_sync;
               out_eop_d   = (byte_cnt_q == LAST_POS);

               if (byte_cnt_q == POS_B1) begin
                  tei_d        = data_in[7];
                  pid_d[12:8]  = data_in[4:0];
               end
               if (byte_cnt_q == POS_B2) begin
                  pid_d[7:0]   = data_in[7:0];
                  pid_valid_d  = 1'b1;
               end

               if (w_at_sync) begin
                  if (w_good) begin
                     bad_cnt_d = '0;
                  end else begin
                     bad_cnt_d  = w_bad_inc;
                     sync_err_d = 1'b1;
                     if (w_bad_inc == UNLK_TGT) begin
                        // Lock lost: the offending byte is dropped.
                        state_d     = ST_HUNT;
                        byte_cnt_d  = '0;
                        good_cnt_d  = '0;
                        bad_cnt_d   = '0;
                        out_valid_d = 1'b0;
                        out_data_d  = out_data_q;
                        out_sop_d   = 1'b0;
                        out_eop_d   = 1'b0;
                     end
                  end
               end
            end

            default: begin
               state_d    = ST_HUNT;
               byte_cnt_d = '0;
               good_cnt_d = '0;
               bad_cnt_d  = '0;
            end
         endcase
      end
   end

`ifdef TS_ERR_CNT_EN
   //---------------------------------------------------------------------------
   // Sync-loss counter: one count per LOCKED->HUNT transition, saturating.
   //---------------------------------------------------------------------------
   logic [15:0] err_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_q <= '0;
      end else if ((state_q == ST_LOCKED) && (state_d == ST_HUNT) &&
                   (err_cnt_q != 16'hFFFF)) begin
         err_cnt_q <= err_cnt_q + 16'd1;
      end
   end

   assign err_cnt = err_cnt_q;
`endif

   assign locked    = (state_q == ST_LOCKED);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sop   = out_sop_q;
   assign out_eop   = out_eop_q;
   assign pid       = pid_q;
   assign pid_valid = pid_valid_q;
   assign tei       = tei_q;
   assign sync_err  = sync_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ts_stream_rx.sv
//==============================================================================
// Module   : tb_ts_stream_rx
// Purpose  : Directed self-checking bench for ts_stream_rx (default params):
//            lock acquisition, forwarding/framing, PID/TEI extraction, input
//            gaps, sync errors, loss of lock and asynchronous reset.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ts_stream_rx;

   localparam int PKT = 188;

   logic        clk;
   logic        rst;
   logic [9:0]  data_in;
   logic        locked;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_sop;
   logic        out_eop;
   logic [12:0] pid;
   logic        pid_valid;
   logic        tei;
   logic        sync_err;
`ifdef TS_ERR_CNT_EN
   logic [15:0] err_cnt;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   ts_stream_rx dut (
      .clk       (clk),
      .rst       (rst),
      .data_in   (data_in),
      .locked    (locked),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sop   (out_sop),
      .out_eop   (out_eop),
      .pid       (pid),
      .pid_valid (pid_valid),
      .tei       (tei),
`ifdef TS_ERR_CNT_EN
      .err_cnt   (err_cnt),
`endif
      .sync_err  (sync_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Present one input word; return #1 after the edge that accepts it, so the
   // registered outputs then reflect that word.
   task automatic drive(input logic [9:0] w);
      data_in = w;
      @(posedge clk);
      #1;
   endtask

   // Send (up to) one packet and check every output after every byte.
   task automatic send_pkt(input string tag, input logic [7:0] s,
                           input logic [7:0] b1, input logic [7:0] b2,
                           input int nbytes, input int gap_max, input bit fake,
                           input bit exp_fwd, input bit exp_lock,
                           input bit exp_serr);
      logic [7:0] b;
      logic       flag;
      logic [2:0] strobes;
      for (int i = 0; i < nbytes; i++) begin
         if (gap_max > 0) begin
            for (int k = 0; k < 1 + (i % gap_max); k++) begin
               drive(10'h000);
               strobes = {out_valid, pid_valid, sync_err};
               n_checks++;
               if (strobes !== 3'b000)
                  $display("FAIL %s gap byte %0d: strobes=%b expected 000", tag, i, strobes);
               else n_pass++;
            end
         end
         flag = (i == 0) || (fake && i == 50);
         if (i == 0)                b = s;
         else if (i == 1)           b = b1;
         else if (i == 2)           b = b2;
         else if (fake && i == 50)  b = 8'h47;
         else                       b = 8'(i * 7 + 3);
         drive({1'b1, flag, b});

         n_checks++;
         if (locked !== exp_lock)
            $display("FAIL %s locked byte %0d: got %b expected %b", tag, i, locked, exp_lock);
         else n_pass++;

         n_checks++;
         if (out_valid !== exp_fwd)
            $display("FAIL %s out_valid byte %0d: got %b expected %b", tag, i, out_valid, exp_fwd);
         else n_pass++;

         if (exp_fwd) begin
            n_checks++;
            if ({out_data, out_sop, out_eop} !== {b, (i == 0), (i == PKT - 1)})
               $display("FAIL %s fwd byte %0d: data=%h sop=%b eop=%b expected data=%h sop=%b eop=%b",
                        tag, i, out_data, out_sop, out_eop, b, (i == 0), (i == PKT - 1));
            else n_pass++;
         end

         n_checks++;
         if (sync_err !== (i == 0 && exp_serr))
            $display("FAIL %s sync_err byte %0d: got %b expected %b", tag, i, sync_err, (i == 0 && exp_serr));
         else n_pass++;

         n_checks++;
         if (pid_valid !== (exp_fwd && i == 2))
            $display("FAIL %s pid_valid byte %0d: got %b expected %b", tag, i, pid_valid, (exp_fwd && i == 2));
         else n_pass++;

         if (exp_fwd && i == 2) begin
            n_checks++;
            if ({tei, pid} !== {b1[7], b1[4:0], b2})
               $display("FAIL %s pid/tei: pid=%h tei=%b expected pid=%h tei=%b",
                        tag, pid, tei, {b1[4:0], b2}, b1[7]);
            else n_pass++;
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      logic [27:0] o;
      o = {locked, out_valid, out_data, out_sop, out_eop, pid, pid_valid, tei, sync_err};
      n_checks++;
      if (o !== 28'h0) $display("FAIL %s outputs: got %h expected 0", tag, o);
      else n_pass++;
`ifdef TS_ERR_CNT_EN
      n_checks++;
      if (err_cnt !== 16'd0) $display("FAIL %s err_cnt: got %0d expected 0", tag, err_cnt);
      else n_pass++;
`endif
   endtask

   task automatic test_reset();
      rst = 1'b1;
      data_in = 10'h000;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      // Valid sync bytes during reset must not advance anything.
      drive(10'h347);
      check_all_zero("reset_with_input");
      rst = 1'b0;
   endtask

   task automatic test_lock();
      send_pkt("lock_p1", 8'h47, 8'h00, 8'h11, PKT, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      send_pkt("lock_p2", 8'h47, 8'h00, 8'h22, PKT, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      send_pkt("lock_p3", 8'h47, 8'h01, 8'h33, PKT, 0, 1'b1, 1'b1, 1'b1, 1'b0);
      send_pkt("lock_p4", 8'h47, 8'h02, 8'h44, PKT, 0, 1'b0, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic test_pid();
      send_pkt("pid_1fff", 8'h47, 8'h9F, 8'hFF, PKT, 0, 1'b0, 1'b1, 1'b1, 1'b0);
      send_pkt("pid_0a5c", 8'h47, 8'h0A, 8'h5C, PKT, 0, 1'b0, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic test_gaps();
      send_pkt("gaps", 8'h47, 8'h45, 8'h67, PKT, 5, 1'b0, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic test_single_bad();
      send_pkt("bad1_a", 8'h46, 8'h00, 8'h01, PKT, 0, 1'b0, 1'b1, 1'b1, 1'b1);
      send_pkt("bad1_good", 8'h47, 8'h00, 8'h02, PKT, 0, 1'b0, 1'b1, 1'b1, 1'b0);
      // Stays locked only if the good sync cleared the bad count.
      send_pkt("bad1_b", 8'h46, 8'h00, 8'h03, PKT, 0, 1'b0, 1'b1, 1'b1, 1'b1);
      send_pkt("bad1_good2", 8'h47, 8'h00, 8'h04, PKT, 0, 1'b0, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic test_unlock();
      send_pkt("unlock_1", 8'h46, 8'h00, 8'h05, PKT, 0, 1'b0, 1'b1, 1'b1, 1'b1);
      send_pkt("unlock_2", 8'h46, 8'h00, 8'h06, PKT, 0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef TS_ERR_CNT_EN
      n_checks++;
      if (err_cnt !== 16'd1) $display("FAIL unlock err_cnt: got %0d expected 1", err_cnt);
      else n_pass++;
`endif
      send_pkt("relock_1", 8'h47, 8'h00, 8'h07, PKT, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      send_pkt("relock_2", 8'h47, 8'h00, 8'h08, PKT, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      send_pkt("relock_3", 8'h47, 8'h00, 8'h09, PKT, 0, 1'b0, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic test_rst_mid();
      send_pkt("rstmid_pre", 8'h47, 8'h12, 8'h34, 100, 0, 1'b0, 1'b1, 1'b1, 1'b0);
      data_in = 10'h000;
      #1;
      rst = 1'b1;
      #1;
      // Checked well before the next clock edge: reset acts asynchronously.
      check_all_zero("rst_async");
      @(posedge clk);
      #2;
      rst = 1'b0;
      send_pkt("rst_relock1", 8'h47, 8'h00, 8'h0A, PKT, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      send_pkt("rst_relock2", 8'h47, 8'h00, 8'h0B, PKT, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      send_pkt("rst_relock3", 8'h47, 8'h00, 8'h0C, PKT, 0, 1'b0, 1'b1, 1'b1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_lock();
      test_pid();
      test_gaps();
      test_single_bad();
      test_unlock();
      test_rst_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ts_stream_rx.md
TS_STREAM_RX -- requirements
Module: ts_stream_rx

Interface
REQ-001 Parameter PKT_LEN, default 188, is the TS packet length in bytes.
REQ-002 Parameter LOCK_CNT, default 3, is the number of consecutive good sync bytes needed to lock.
REQ-003 Parameter UNLOCK_CNT, default 2, is the number of consecutive bad sync bytes needed to drop lock.
REQ-004 Port clk, input, 1, is the single clock; all logic is on rising edge.
REQ-005 Port rst, input, 1, is the asynchronous, active-high reset.
REQ-006 Port data_in, input, 10, carries the FIFO output word: [9] valid, [8] sync flag, [7:0] TS byte.
REQ-007 Port locked, output, 1, is high while the state is LOCKED.
REQ-008 Port out_valid, output, 1, qualifies out_data, out_sop and out_eop.
REQ-009 Port out_data, output, 8, is the forwarded TS byte.
REQ-010 Port out_sop, output, 1, marks packet byte 0; out_eop, output, 1, marks byte PKT_LEN-1.
REQ-011 Port pid, output, 13, is the PID of the current packet; pid_valid, output, 1, is a one-cycle strobe.
REQ-012 Port tei, output, 1, is the transport_error_indicator of the current packet.
REQ-013 Port sync_err, output, 1, pulses for one cycle on a bad sync byte while LOCKED.
REQ-014 Port err_cnt, output, 16, is the sync-loss counter (present only with TS_ERR_CNT_EN).

Function
REQ-015 A byte is accepted only in cycles where data_in[9]=1; other cycles leave all state unchanged.
REQ-016 A good sync byte is an accepted byte with data_in[8]=1 and data_in[7:0]=0x47.
REQ-017 The FSM SHALL have three states: HUNT, VERIFY and LOCKED.
REQ-018 In HUNT, a good sync byte moves the FSM to VERIFY, sets byte_cnt=1 and sets good_cnt=1; all other bytes are discarded.
REQ-019 byte_cnt counts accepted bytes and wraps from PKT_LEN-1 to 0; the byte accepted at byte_cnt=0 is the expected sync position.
REQ-020 In VERIFY, a good sync at the expected position increments good_cnt; when good_cnt reaches LOCK_CNT, the FSM moves to LOCKED.
REQ-021 In VERIFY, a non-good byte at the expected position moves the FSM to HUNT; that byte is not re-evaluated as a candidate sync.
REQ-022 In VERIFY and LOCKED, data_in[8] at any position other than the expected one is ignored.
REQ-023 In LOCKED, every accepted byte is forwarded with out_valid=1 exactly one cycle later (registered, latency 1).
REQ-024 In LOCKED, out_sop=1 with byte_cnt=0 and out_eop=1 with byte_cnt=PKT_LEN-1.
REQ-025 The byte completing lock (the LOCK_CNT-th good sync) is forwarded with out_sop=1.
REQ-026 pid is loaded from byte1[4:0] and byte2[7:0], and tei from byte1[7].
REQ-027 pid_valid pulses one cycle after byte 2 is accepted in LOCKED.
REQ-028 In LOCKED, a bad expected-position byte increments bad_cnt and pulses sync_err; a good one clears bad_cnt.
REQ-029 When bad_cnt reaches UNLOCK_CNT, the FSM moves to HUNT and that byte is not forwarded; otherwise the byte is forwarded with out_sop=1.
REQ-030 out_valid, out_sop, out_eop, pid_valid and sync_err are zero in every cycle not specified above.

Reset
REQ-031 While rst=1, the FSM is in HUNT, all counters are 0, and all outputs are 0 (pid=0, tei=0, err_cnt=0).
REQ-032 Asserting rst mid-packet clears the outputs immediately (asynchronous), and hunting restarts on the first clk edge after release.

Configuration
REQ-033 With TS_ERR_CNT_EN defined, err_cnt increments by 1 on each LOCKED-to-HUNT transition, saturates at 0xFFFF, and is cleared only by rst.
REQ-034 Without TS_ERR_CNT_EN, port err_cnt and its logic are absent, and all other behaviour is identical.

Verification
REQ-035 Stream of 4 valid packets (0x47 with sync=1, then 187 bytes) -> locked rises on byte 0 of packet 3; packet 3 bytes are forwarded with sop/eop at byte 0/187.
REQ-036 Locked stream, packet with byte1=0x9F, byte2=0xFF -> pid=0x1FFF, tei=1, pid_valid pulses once, one cycle after byte 2.
REQ-037 Locked stream, valid=0 gaps of 1-5 cycles inserted between bytes -> output byte sequence unchanged, out_valid low during the gaps, latency 1.
REQ-038 Locked stream, two consecutive packets start with 0x46 -> sync_err pulses twice, locked falls at the second one, err_cnt=1 (macro on), that byte is not forwarded.
REQ-039 Locked stream, one bad sync followed by a good one -> sync_err pulses once, locked stays high, bad_cnt clears.
REQ-040 rst asserted at byte 100 of a locked packet -> all outputs 0 immediately; after release, relock requires LOCK_CNT fresh good syncs.
